// File: rtl/aznable_pkg.sv
// Shared definitions for the VRAM fill DMA: register offsets, TARGET bits, FSM states.
// Used by the fill engine and anything decoding its register window.
package aznable_pkg;

  localparam logic [2:0] REG_DST_LO = 3'd0;
  localparam logic [2:0] REG_DST_HI = 3'd1;
  localparam logic [2:0] REG_LEN_LO = 3'd2;
  localparam logic [2:0] REG_LEN_HI = 3'd3;
  localparam logic [2:0] REG_VALUE  = 3'd4;
  localparam logic [2:0] REG_TARGET = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;
  localparam logic [2:0] REG_RSVD   = 3'd7;

  localparam int TGT_CHRAM = 0;
  localparam int TGT_FGCOL = 1;
  localparam int TGT_BGCOL = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_t;

endpackage

// File: rtl/vram_fill_dma_if.sv
// CPU bus, register read-back and VRAM CPU-side port bundle for the fill DMA.
// master = CPU/bus side, slave = fill engine.
interface vram_fill_dma_if #(
  parameter int ADDR_W = 11
);
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_dout;
  logic              cpu_wr_n;
  logic              reg_cs;
  logic              chram_cs;
  logic              fgcolram_cs;
  logic              bgcolram_cs;
  logic [7:0]        reg_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              chram_wr;
  logic              fgcolram_wr;
  logic              bgcolram_wr;
  logic              busy;

  modport master (
    output cpu_addr, cpu_dout, cpu_wr_n, reg_cs, chram_cs, fgcolram_cs, bgcolram_cs,
    input  reg_dout, ram_addr, ram_data, chram_wr, fgcolram_wr, bgcolram_wr, busy
  );

  modport slave (
    input  cpu_addr, cpu_dout, cpu_wr_n, reg_cs, chram_cs, fgcolram_cs, bgcolram_cs,
    output reg_dout, ram_addr, ram_data, chram_wr, fgcolram_wr, bgcolram_wr, busy
  );
endinterface

// File: rtl/vram_fill_dma.sv
// Fills a span of char/colour VRAM with a constant byte, stealing only cycles the CPU leaves idle.
// One write per free cycle; busy rises the cycle after start; CPU VRAM access always wins and is never stalled.
module vram_fill_dma
  import aznable_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 12
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  vram_fill_dma_if.slave bus
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);

  fill_state_t       state;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  rem;
  logic [7:0]        value;
  logic [7:0]        val_q;
  logic [2:0]        target;
  logic [2:0]        tgt_q;
  logic              done;

  logic [2:0] sel;
  logic       reg_wr;
  logic       stat_rd;
  logic       vram_cs;
  logic       fill_wr;
  logic       start_req;
  logic       cpu_wr_en;
  logic       unused_addr;

  assign sel         = bus.cpu_addr[2:0];
  assign reg_wr      = bus.reg_cs && !bus.cpu_wr_n;
  assign stat_rd     = bus.reg_cs && bus.cpu_wr_n && (sel == REG_CTRL);
  assign vram_cs     = bus.chram_cs || bus.fgcolram_cs || bus.bgcolram_cs;
  assign fill_wr     = (state == ST_RUN) && !vram_cs;
  assign start_req   = reg_wr && (sel == REG_CTRL) && bus.cpu_dout[0];
  assign cpu_wr_en   = reset_n && !bus.cpu_wr_n;
  assign unused_addr = ^bus.cpu_addr[15:ADDR_W];

  always_comb begin
    bus.reg_dout = 8'h00;
    case (sel)
      REG_DST_LO: bus.reg_dout = dst[7:0];
      REG_DST_HI: bus.reg_dout = 8'(dst[ADDR_W-1:8]);
      REG_LEN_LO: bus.reg_dout = len[7:0];
      REG_LEN_HI: bus.reg_dout = 8'(len[LEN_W-1:8]);
      REG_VALUE:  bus.reg_dout = value;
      REG_TARGET: bus.reg_dout = {5'b0, target};
      REG_CTRL:   bus.reg_dout = {6'b0, done, (state == ST_RUN)};
      REG_RSVD:   bus.reg_dout = 8'h00;
      default:    bus.reg_dout = 8'h00;
    endcase
  end

  // Fill owns the VRAM port only in cycles with no CPU VRAM select, so the two never collide.
  assign bus.busy        = (state == ST_RUN);
  assign bus.ram_addr    = fill_wr ? ptr : bus.cpu_addr[ADDR_W-1:0];
  assign bus.ram_data    = fill_wr ? val_q : bus.cpu_dout;
  assign bus.chram_wr    = fill_wr ? tgt_q[TGT_CHRAM] : (cpu_wr_en && bus.chram_cs);
  assign bus.fgcolram_wr = fill_wr ? tgt_q[TGT_FGCOL] : (cpu_wr_en && bus.fgcolram_cs);
  assign bus.bgcolram_wr = fill_wr ? tgt_q[TGT_BGCOL] : (cpu_wr_en && bus.bgcolram_cs);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      dst    <= '0;
      ptr    <= '0;
      len    <= '0;
      rem    <= '0;
      value  <= '0;
      val_q  <= '0;
      target <= '0;
      tgt_q  <= '0;
      done   <= 1'b0;
    end else begin
      if (stat_rd) done <= 1'b0;

      if (reg_wr && state == ST_IDLE) begin
        case (sel)
          REG_DST_LO: dst[7:0]         <= bus.cpu_dout;
          REG_DST_HI: dst[ADDR_W-1:8]  <= bus.cpu_dout[ADDR_W-9:0];
          REG_LEN_LO: len[7:0]         <= bus.cpu_dout;
          REG_LEN_HI: len[LEN_W-1:8]   <= bus.cpu_dout[LEN_W-9:0];
          REG_VALUE:  value            <= bus.cpu_dout;
          REG_TARGET: target           <= bus.cpu_dout[2:0];
          default: ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (start_req) begin
            if (len != '0 && target != 3'b000) begin
              ptr   <= dst;
              rem   <= (len > MAX_LEN) ? MAX_LEN : len;
              val_q <= value;
              tgt_q <= target;
              done  <= 1'b0;
              state <= ST_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (fill_wr) begin
            ptr <= ptr + 1'b1;
            rem <= rem - 1'b1;
            // Completion overrides a same-cycle STATUS read so the done event is never lost.
            if (rem == LEN_W'(1)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_fill_dma.sv
// Bench for vram_fill_dma: directed scenarios plus randomized fills and CPU traffic,
// every cycle compared against a queue-of-expected-writes reference model.
module tb_vram_fill_dma;

  localparam int AW  = 11;
  localparam int LW  = 12;
  localparam int VSZ = 2048;

  logic clk_sys = 1'b0;
  logic reset_n;

  initial forever #5 clk_sys = ~clk_sys;

  vram_fill_dma_if #(.ADDR_W(AW)) bus ();

  vram_fill_dma #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [10:0] a;
    logic [7:0]  d;
    logic [2:0]  t;
  } wr_t;

  wr_t         exp_q[$];
  logic [10:0] m_dst;
  logic [11:0] m_len;
  logic [7:0]  m_val;
  logic [2:0]  m_tgt;
  logic        m_busy;
  logic        m_done;
  logic        m_fill_now;
  int          m_pops;

  int vectors = 0;
  int miscompares = 0;
  int obs_busy, obs_fill, obs_fill_all, obs_cpu_fg;
  logic [7:0] last_rd;
  string phase = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] s);
    case (s)
      3'd0:    return m_dst[7:0];
      3'd1:    return {5'b0, m_dst[10:8]};
      3'd2:    return m_len[7:0];
      3'd3:    return {4'b0, m_len[11:8]};
      3'd4:    return m_val;
      3'd5:    return {5'b0, m_tgt};
      3'd6:    return {6'b0, m_done, m_busy};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_dst = '0; m_len = '0; m_val = '0; m_tgt = '0;
    m_busy = 1'b0; m_done = 1'b0; m_fill_now = 1'b0; m_pops = 0;
  endtask

  task automatic clear_obs();
    obs_busy = 0; obs_fill = 0; obs_fill_all = 0; obs_cpu_fg = 0;
  endtask

  task automatic check_cycle();
    logic [2:0]  cs;
    logic [2:0]  ewr;
    logic [10:0] ea;
    logic [7:0]  ed;
    cs = {bus.bgcolram_cs, bus.fgcolram_cs, bus.chram_cs};
    m_fill_now = m_busy && (cs == 3'b000) && (exp_q.size() > 0);
    if (m_fill_now) begin
      ea = exp_q[0].a; ed = exp_q[0].d; ewr = exp_q[0].t;
    end else begin
      ea = bus.cpu_addr[10:0]; ed = bus.cpu_dout; ewr = bus.cpu_wr_n ? 3'b000 : cs;
    end
    check("outputs",
          {9'b0, bus.busy, bus.bgcolram_wr, bus.fgcolram_wr, bus.chram_wr, bus.ram_addr, bus.ram_data},
          {9'b0, m_busy, ewr, ea, ed});
    last_rd = bus.reg_dout;
    if (bus.reg_cs) check("reg_dout", 32'(bus.reg_dout), 32'(model_read(bus.cpu_addr[2:0])));
    if (bus.busy) obs_busy++;
    if (cs == 3'b000 && (bus.chram_wr || bus.fgcolram_wr || bus.bgcolram_wr)) obs_fill++;
    if (cs == 3'b000 && bus.chram_wr && bus.fgcolram_wr && bus.bgcolram_wr) obs_fill_all++;
    if (cs != 3'b000 && bus.fgcolram_wr) obs_cpu_fg++;
  endtask

  task automatic model_edge();
    logic       old_busy;
    logic [2:0] s;
    int         n;
    wr_t        w;
    old_busy = m_busy;
    s = bus.cpu_addr[2:0];
    if (bus.reg_cs && bus.cpu_wr_n && s == 3'd6) m_done = 1'b0;
    if (m_fill_now) begin
      void'(exp_q.pop_front());
      m_pops++;
      if (exp_q.size() == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
    if (bus.reg_cs && !bus.cpu_wr_n && !old_busy) begin
      case (s)
        3'd0: m_dst[7:0]  = bus.cpu_dout;
        3'd1: m_dst[10:8] = bus.cpu_dout[2:0];
        3'd2: m_len[7:0]  = bus.cpu_dout;
        3'd3: m_len[11:8] = bus.cpu_dout[3:0];
        3'd4: m_val       = bus.cpu_dout;
        3'd5: m_tgt       = bus.cpu_dout[2:0];
        3'd6: if (bus.cpu_dout[0]) begin
          if (m_len != 12'd0 && m_tgt != 3'd0) begin
            n = (int'(m_len) > VSZ) ? VSZ : int'(m_len);
            for (int i = 0; i < n; i++) begin
              w.a = 11'((int'(m_dst) + i) % VSZ);
              w.d = m_val;
              w.t = m_tgt;
              exp_q.push_back(w);
            end
            m_busy = 1'b1;
            m_done = 1'b0;
          end else begin
            m_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    #1;
    check_cycle();
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
  endtask

  task automatic set_idle();
    bus.reg_cs = 1'b0; bus.cpu_wr_n = 1'b1;
    bus.chram_cs = 1'b0; bus.fgcolram_cs = 1'b0; bus.bgcolram_cs = 1'b0;
    bus.cpu_addr = 16'($urandom);
    bus.cpu_dout = 8'($urandom);
  endtask

  task automatic reg_wr(input logic [2:0] s, input logic [7:0] d);
    set_idle();
    bus.reg_cs = 1'b1; bus.cpu_wr_n = 1'b0;
    bus.cpu_addr = {13'h0F20, s};
    bus.cpu_dout = d;
    tick();
  endtask

  task automatic reg_rd(input logic [2:0] s);
    set_idle();
    bus.reg_cs = 1'b1;
    bus.cpu_addr = {13'h0F20, s};
    tick();
  endtask

  task automatic config_fill(input logic [10:0] d, input logic [11:0] l, input logic [7:0] v, input logic [2:0] t);
    reg_wr(3'd0, d[7:0]);
    reg_wr(3'd1, {5'b0, d[10:8]});
    reg_wr(3'd2, l[7:0]);
    reg_wr(3'd3, {4'b0, l[11:8]});
    reg_wr(3'd4, v);
    reg_wr(3'd5, {5'b0, t});
  endtask

  task automatic run_idle(input int max);
    int g;
    g = 0;
    while (m_busy && g < max) begin
      set_idle();
      tick();
      g++;
    end
  endtask

  initial begin
    int          g;
    int          r;
    logic [11:0] rl;
    logic [2:0]  rt;

    reset_n = 1'b0;
    set_idle();
    model_reset();
    clear_obs();
    @(negedge clk_sys);

    phase = "reset";
    for (int i = 0; i < 8; i++) begin
      set_idle();
      bus.reg_cs = 1'b1;
      bus.cpu_addr = {13'h0F20, 3'(i)};
      #1;
      check("rst_reg", 32'(bus.reg_dout), 32'h0);
      @(negedge clk_sys);
    end
    set_idle();
    bus.chram_cs = 1'b1; bus.fgcolram_cs = 1'b1; bus.cpu_wr_n = 1'b0;
    #1;
    check("rst_wr_busy", 32'({bus.busy, bus.bgcolram_wr, bus.fgcolram_wr, bus.chram_wr}), 32'h0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    set_idle();
    tick();

    phase = "screen_clear";
    config_fill(11'h000, 12'h4B0, 8'h20, 3'd1);
    reg_wr(3'd6, 8'h01);
    clear_obs();
    run_idle(1300);
    set_idle();
    tick();
    check("busy_cycles", 32'(obs_busy), 32'd1200);
    check("fill_writes", 32'(obs_fill), 32'd1200);
    reg_rd(3'd6);
    check("status_done", 32'(last_rd), 32'h02);
    reg_rd(3'd6);
    check("status_clr", 32'(last_rd), 32'h00);

    phase = "wrap";
    config_fill(11'h7FE, 12'd4, 8'($urandom), 3'd7);
    reg_wr(3'd6, 8'h01);
    clear_obs();
    run_idle(20);
    set_idle();
    tick();
    check("all3_writes", 32'(obs_fill_all), 32'd4);

    phase = "cpu_priority";
    config_fill(11'h300, 12'd16, 8'hA5, 3'd1);
    reg_wr(3'd6, 8'h01);
    clear_obs();
    for (int i = 0; i < 32; i++) begin
      set_idle();
      if (i % 2 == 0) begin
        bus.fgcolram_cs = 1'b1;
        bus.cpu_wr_n = 1'b0;
      end
      tick();
    end
    set_idle();
    tick();
    check("busy_cycles", 32'(obs_busy), 32'd32);
    check("fill_writes", 32'(obs_fill), 32'd16);
    check("cpu_writes", 32'(obs_cpu_fg), 32'd16);

    phase = "len_zero";
    config_fill(11'($urandom), 12'd0, 8'h11, 3'd1);
    reg_wr(3'd6, 8'h01);
    clear_obs();
    set_idle();
    tick();
    reg_rd(3'd6);
    check("status_done", 32'(last_rd), 32'h02);
    reg_rd(3'd6);
    check("status_clr", 32'(last_rd), 32'h00);
    check("no_busy", 32'(obs_busy), 32'd0);

    phase = "start_while_busy";
    config_fill(11'h100, 12'd50, 8'h5A, 3'd2);
    reg_wr(3'd6, 8'h01);
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      set_idle();
      tick();
    end
    reg_wr(3'd0, 8'h33);
    reg_wr(3'd4, 8'hEE);
    reg_wr(3'd6, 8'h01);
    run_idle(100);
    set_idle();
    tick();
    check("fill_writes", 32'(obs_fill), 32'd50);
    reg_rd(3'd0);
    check("dst_kept", 32'(last_rd), 32'h00);
    reg_rd(3'd4);
    check("val_kept", 32'(last_rd), 32'h5A);

    phase = "clamp";
    config_fill(11'h005, 12'hFFF, 8'h77, 3'd4);
    reg_wr(3'd6, 8'h01);
    clear_obs();
    run_idle(2200);
    set_idle();
    tick();
    check("fill_writes", 32'(obs_fill), 32'd2048);

    phase = "reset_abort";
    config_fill(11'h010, 12'd100, 8'h3C, 3'd1);
    m_pops = 0;
    reg_wr(3'd6, 8'h01);
    g = 0;
    while (m_pops < 4 && g < 50) begin
      set_idle();
      tick();
      g++;
    end
    set_idle();
    #1;
    check_cycle();
    check("fifth_write", 32'(bus.chram_wr), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort", 32'({bus.busy, bus.bgcolram_wr, bus.fgcolram_wr, bus.chram_wr}), 32'h0);
    model_reset();
    @(negedge clk_sys);
    reset_n = 1'b1;
    clear_obs();
    for (int i = 0; i < 20; i++) begin
      set_idle();
      tick();
    end
    check("no_fill_after_rst", 32'(obs_fill), 32'd0);
    check("no_busy_after_rst", 32'(obs_busy), 32'd0);
    reg_rd(3'd2);
    check("len_cleared", 32'(last_rd), 32'h00);

    phase = "random";
    for (int f = 0; f < 25; f++) begin
      rl = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 48));
      rt = 3'($urandom_range(0, 7));
      config_fill(11'($urandom), rl, 8'($urandom), rt);
      reg_wr(3'd6, 8'($urandom) | 8'h01);
      g = 0;
      while (m_busy && g < 500) begin
        set_idle();
        r = $urandom_range(0, 9);
        if (r < 3) begin
          case ($urandom_range(0, 2))
            0:       bus.chram_cs = 1'b1;
            1:       bus.fgcolram_cs = 1'b1;
            default: bus.bgcolram_cs = 1'b1;
          endcase
          bus.cpu_wr_n = 1'($urandom);
        end else if (r == 3) begin
          bus.reg_cs = 1'b1;
          bus.cpu_addr = {13'h0F20, 3'($urandom)};
        end
        tick();
        g++;
      end
      reg_rd(3'd6);
      set_idle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_fill_dma.md
VRAM_FILL_DMA -- requirements
Module: vram_fill_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, VRAM address width (2048-byte char/colour RAMs).
REQ-002 SHALL have parameter LEN_W, default 12, length register width (max length 2^ADDR_W).
REQ-003 SHALL have the following ports; one clock; reset is asynchronous and active-low:
- clk_sys  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- cpu_addr  in  16  CPU address bus
- cpu_dout  in  8  CPU write data
- cpu_wr_n  in  1  CPU write strobe, active-low
- reg_cs  in  1  register window select (0x7900-0x79FF, decoded externally)
- chram_cs, fgcolram_cs, bgcolram_cs  in  1 each  CPU selects for the three VRAMs
- reg_dout  out  8  register read data to CPU data mux
- ram_addr  out  ADDR_W  address to VRAM CPU-side port
- ram_data  out  8  write data to VRAM CPU-side port
- chram_wr, fgcolram_wr, bgcolram_wr  out  1 each  VRAM write enables
- busy  out  1  fill in progress

Function
REQ-004 Registers SHALL be selected by cpu_addr[2:0]: 0 DST_LO, 1 DST_HI (bits [ADDR_W-9:0] used), 2 LEN_LO, 3 LEN_HI, 4 VALUE, 5 TARGET (bit0 chram, bit1 fgcol, bit2 bgcol), 6 CTRL/STATUS, 7 reserved (reads 0).
REQ-005 Register write SHALL occur on any clk_sys edge with reg_cs=1 and cpu_wr_n=0.
REQ-006 Writes to registers 0-5 SHALL be ignored while busy=1.
REQ-007 Reads SHALL be combinational from cpu_addr[2:0]; STATUS read returns {6'b0, done, busy}.
REQ-008 Write to CTRL with cpu_dout[0]=1 in IDLE SHALL start a fill if LEN!=0 and TARGET[2:0]!=0; otherwise set done=1 immediately and stay IDLE.
REQ-009 CTRL start while busy SHALL be ignored.
REQ-010 LEN greater than 2^ADDR_W SHALL be clamped to 2^ADDR_W at start.
REQ-011 FSM SHALL have states IDLE and RUN; IDLE->RUN on accepted start; RUN->IDLE after last write issued.
REQ-012 On start, the engine SHALL latch DST, clamped LEN, VALUE, TARGET into working registers, clear done, assert busy next cycle.
REQ-013 In RUN, a fill write SHALL issue in each cycle where chram_cs, fgcolram_cs and bgcolram_cs are all 0 (CPU has absolute priority; no CPU stall).
REQ-014 A fill write SHALL drive ram_addr=working pointer, ram_data=VALUE, and the *_wr outputs selected by TARGET, all in the same cycle.
REQ-015 After each fill write the pointer SHALL increment modulo 2^ADDR_W (0x7FF wraps to 0x000) and the remaining count SHALL decrement.
REQ-016 When the write with remaining count=1 issues, the FSM SHALL return to IDLE next cycle, busy=0 and done=1 (sticky) that same next cycle.
REQ-017 done SHALL clear on a STATUS read (reg_cs=1, cpu_wr_n=1, cpu_addr[2:0]=6) or on an accepted start.
REQ-018 When no fill write is issued, ram_addr/ram_data SHALL pass cpu_addr[ADDR_W-1:0]/cpu_dout and *_wr SHALL equal !cpu_wr_n && the respective *_cs.
REQ-019 Fill and CPU writes SHALL never be asserted in the same cycle.

Reset
REQ-020 On reset_n=0 asynchronously: FSM=IDLE, busy=0, done=0, all registers and working registers=0, *_wr=0.
REQ-021 Reset mid-fill SHALL abort immediately; no further fill writes after reset deasserts until a new start.

Structure
REQ-022 Register offsets, TARGET bit positions and FSM state encoding SHALL live in shared package aznable_pkg.
REQ-023 Register file and FSM/datapath SHALL be one module; no sub-module required.

Verification
REQ-024 DST=0x000, LEN=0x4B0, VALUE=0x20, TARGET=1, start, no CPU VRAM traffic -> 1200 chram writes at 0x000-0x4AF, busy high 1200 cycles, done=1 after.
REQ-025 DST=0x7FE, LEN=4, TARGET=7 -> writes at 0x7FE, 0x7FF, 0x000, 0x001 with all three *_wr high each write.
REQ-026 Fill LEN=16 with CPU writing fgcolram every other cycle -> CPU writes land unchanged at CPU addresses, fill completes in 32 cycles, no cycle with both sources.
REQ-027 LEN=0 start -> no writes, busy stays 0, STATUS reads 0x02, second STATUS read 0x00.
REQ-028 Start during busy with new DST/VALUE -> ignored, original fill completes unchanged.
REQ-029 reset_n low at fill write 5 of 100 -> busy=0 and no *_wr asserted by fill after reset release.
